// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA scan-out from a dual-port image buffer, upscaled by 2**SCALE_SHIFT.
// Two-stage pipeline: counters -> buffer address/flags -> RGB444 + syncs.
module vga_frame_reader #(
    parameter int DATA_WIDTH  = 12,
    parameter int ADDR_WIDTH  = 15,
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int H_VIS       = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VIS       = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] rgb,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic                  frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HCW   = $clog2(H_TOT);
    localparam int VCW   = $clog2(V_TOT);
    localparam int H_IMG = IMG_W << SCALE_SHIFT;
    localparam int V_IMG = IMG_H << SCALE_SHIFT;

    logic [HCW-1:0] hcnt;
    logic [VCW-1:0] vcnt;
    logic [31:0]    hc, vc, addr_full;
    logic           vis, in_img, hs0, vs0, f0;
    logic           vis_d, in_img_d, hs_d, vs_d, f_d;

    // Widen the counters once so every comparison below is 32-bit unsigned
    assign hc = 32'(hcnt);
    assign vc = 32'(vcnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hc == H_TOT - 1) begin
            hcnt <= '0;
            vcnt <= (vc == V_TOT - 1) ? '0 : VCW'(vc + 32'd1);
        end else begin
            hcnt <= HCW'(hc + 32'd1);
        end
    end

    always_comb begin
        vis       = (hc < H_VIS) && (vc < V_VIS);
        in_img    = vis && (hc < H_IMG) && (vc < V_IMG);
        hs0       = !((hc >= H_VIS + H_FP) && (hc < H_VIS + H_FP + H_SYNC));
        vs0       = !((vc >= V_VIS + V_FP) && (vc < V_VIS + V_FP + V_SYNC));
        f0        = (hc == 0) && (vc == 0);
        addr_full = (vc >> SCALE_SHIFT) * IMG_W + (hc >> SCALE_SHIFT);
    end

    // Outside the image the all-ones location is read; the buffer keeps it black
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_addr <= '1;
            vis_d     <= 1'b0;
            in_img_d  <= 1'b0;
            hs_d      <= 1'b1;
            vs_d      <= 1'b1;
            f_d       <= 1'b0;
        end else begin
            read_addr <= in_img ? addr_full[ADDR_WIDTH-1:0] : '1;
            vis_d     <= vis;
            in_img_d  <= in_img;
            hs_d      <= hs0;
            vs_d      <= vs0;
            f_d       <= f0;
        end
    end

    // q has settled on the negedge since read_addr was launched
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb         <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            rgb         <= (vis_d && in_img_d) ? q : '0;
            hsync       <= hs_d;
            vsync       <= vs_d;
            de          <= vis_d;
            frame_start <= f_d;
        end
    end

endmodule
